// File: rtl/dp_types_pkg.sv
// Shared datapath types: hazard-controller state and the per-register enable/flush bundle.
package dp_types_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        DDONE = 2'd2,
        HALT  = 2'd3
    } hzd_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } reg_ctrl_t;

    typedef struct packed {
        logic      pc_en;
        reg_ctrl_t if_id;
        reg_ctrl_t id_ex;
        reg_ctrl_t ex_mem;
        reg_ctrl_t mem_wb;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_reg_if.sv
// Enable/flush bundle between the hazard controller and the four pipeline registers.
interface pipeline_reg_if;
    import dp_types_pkg::*;

    pipe_ctrl_t ctrl;

    modport hazard (output ctrl);
    modport regs   (input  ctrl);

endinterface

// File: rtl/load_use_detect.sv
// Flags an ID-stage read of a register still being loaded by the EX-stage instruction.
module load_use_detect #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    output logic              lu_o
);

    // Register 0 is hardwired, so a load into it never creates a dependency.
    assign lu_o = ex_memread_i && (ex_rd_i != '0) &&
                  ((ex_rd_i == id_rs_i) || (ex_rd_i == id_rt_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: memory-wait FSM, load-use bubbles, MEM-stage redirects, halt.
module pipeline_hazard_ctrl
    import dp_types_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   mem_dren,
    input  logic                   mem_dwen,
    input  logic                   mem_pcsrc,
    input  logic                   ex_memread,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   wb_halt,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   mem_wb_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   mem_wb_flush,
    output logic                   dmem_mask,
    output logic                   halt,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    hzd_state_t             state_q;
    logic                   halt_q;
    logic [STALL_CNT_W-1:0] cnt_q;
    logic                   dreq;
    logic                   adv;
    logic                   lu;
    logic                   stall_evt;
    pipe_ctrl_t             ctrl;

    pipeline_reg_if u_pipe_if ();

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_memread_i (ex_memread),
        .ex_rd_i      (ex_rd),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .lu_o         (lu)
    );

    assign dreq = mem_dren | mem_dwen;

    // Advance is forced low under reset so every enable/flush reads 0 while RST is held.
    always_comb begin
        adv = 1'b0;
        unique case (state_q)
            RUN, DWAIT: adv = ihit & (~dreq | dhit);
            DDONE:      adv = ihit;
            default:    adv = 1'b0;
        endcase
        if (RST) adv = 1'b0;
    end

    always_comb begin
        ctrl = '0;
        if (adv) begin
            ctrl.pc_en     = 1'b1;
            ctrl.if_id.en  = 1'b1;
            ctrl.id_ex.en  = 1'b1;
            ctrl.ex_mem.en = 1'b1;
            ctrl.mem_wb.en = 1'b1;
            if (mem_pcsrc) begin
                ctrl.if_id.flush  = 1'b1;
                ctrl.id_ex.flush  = 1'b1;
                ctrl.ex_mem.flush = 1'b1;
            end else if (lu) begin
                ctrl.pc_en       = 1'b0;
                ctrl.if_id.en    = 1'b0;
                ctrl.id_ex.flush = 1'b1;
            end
        end
    end

    assign stall_evt = (state_q != HALT) && (!adv || (lu && !mem_pcsrc));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (wb_halt && adv) begin
                        state_q <= HALT;
                        halt_q  <= 1'b1;
                    end else if (dreq && !dhit) begin
                        state_q <= DWAIT;
                    end else if (dreq && dhit && !ihit) begin
                        state_q <= DDONE;
                    end
                end
                DWAIT: begin
                    if (dhit && ihit)       state_q <= RUN;
                    else if (dhit && !ihit) state_q <= DDONE;
                end
                DDONE: begin
                    if (ihit) state_q <= RUN;
                end
                default: state_q <= HALT;
            endcase
            if (stall_evt && (cnt_q != '1)) cnt_q <= cnt_q + STALL_CNT_W'(1);
        end
    end

    assign u_pipe_if.ctrl = ctrl;

    assign pc_en        = u_pipe_if.ctrl.pc_en;
    assign if_id_en     = u_pipe_if.ctrl.if_id.en;
    assign id_ex_en     = u_pipe_if.ctrl.id_ex.en;
    assign ex_mem_en    = u_pipe_if.ctrl.ex_mem.en;
    assign mem_wb_en    = u_pipe_if.ctrl.mem_wb.en;
    assign if_id_flush  = u_pipe_if.ctrl.if_id.flush;
    assign id_ex_flush  = u_pipe_if.ctrl.id_ex.flush;
    assign ex_mem_flush = u_pipe_if.ctrl.ex_mem.flush;
    assign mem_wb_flush = u_pipe_if.ctrl.mem_wb.flush;

    assign dmem_mask = !RST && (state_q == DDONE);
    assign halt      = !RST && halt_q;
    assign stall_cnt = RST ? '0 : cnt_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller that drives the enable and flush inputs of all four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Arbitrates between instruction-fetch hits, data-memory waits, load-use hazards, taken branches/jumps resolved in MEM, and halt.
- Holds a small FSM so that a data access that completes before the fetch hit is not reissued.
- Sits in the datapath top, beside the pipeline register instances.

Parameters:
REG_AW, 5, register-index width
STALL_CNT_W, 32, width of stall performance counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
mem_dren  in  1  MEM-stage load request (from EX/MEM)
mem_dwen  in  1  MEM-stage store request (from EX/MEM)
mem_pcsrc  in  1  MEM-stage branch/jump taken
ex_memread  in  1  EX-stage instruction is a load (from ID/EX)
ex_rd  in  REG_AW  EX-stage destination register
id_rs  in  REG_AW  ID-stage source register rs
id_rt  in  REG_AW  ID-stage source register rt
wb_halt  in  1  halt instruction in WB (from MEM/WB)
pc_en  out  1  PC update enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  register flushes
dmem_mask  out  1  suppress MEM-stage request toward the cache
halt  out  1  sticky halt flag
stall_cnt  out  STALL_CNT_W  stalled/bubbled cycles since reset

Behaviour:
- Reset: on the CLK edge with RST=1, state goes to RUN, halt goes to 0, stall_cnt goes to 0. While RST=1, every output is 0, including all enables and flushes. RST has priority over all other inputs, including mid-wait.
- States:
  - RUN: normal operation.
  - DWAIT: data request outstanding.
  - DDONE: data returned, fetch still pending.
  - HALT: terminal until reset.
- dreq = mem_dren | mem_dwen.
- adv, the pipeline-advance condition, is combinational:
  - RUN/DWAIT: adv = ihit & (~dreq | dhit).
  - DDONE: adv = ihit.
  - HALT: adv = 0.
- Load-use hazard: lu = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (ex_rd == id_rt)).
- Output equations, all combinational from state plus inputs, with no added latency:
  - adv=0: all enables and all flushes are 0.
  - adv=1 and mem_pcsrc=1 (wins over lu):
    - All enables are 1.
    - if_id_flush = id_ex_flush = ex_mem_flush = 1.
    - mem_wb_flush = 0.
  - adv=1, lu=1, mem_pcsrc=0:
    - pc_en = if_id_en = 0.
    - id_ex_en = 1 and id_ex_flush = 1, which inserts a bubble.
    - ex_mem_en = mem_wb_en = 1.
  - adv=1, otherwise: all enables are 1 and all flushes are 0.
  - A flush is only ever asserted together with its register's enable.
- dmem_mask = 1 only in DDONE; otherwise 0.
- Transitions, evaluated when RST=0:
  - RUN:
    - wb_halt & adv goes to HALT.
    - dreq & ~dhit goes to DWAIT.
    - dreq & dhit & ~ihit goes to DDONE.
    - Otherwise stays in RUN.
  - DWAIT:
    - dhit & ihit goes to RUN.
    - dhit & ~ihit goes to DDONE.
    - Otherwise stays in DWAIT.
  - DDONE: ihit goes to RUN; otherwise stays in DDONE.
  - HALT: stays in HALT. All enables are 0; halt=1 is registered and asserted from the cycle after entry.
- stall_cnt:
  - Increments by 1 on each non-HALT cycle where adv=0, or where adv=1 & lu=1 & ~mem_pcsrc.
  - Saturates at all-ones; no wrap.
- Simultaneous events:
  - ihit and dhit in the same cycle in DWAIT: advance directly, with no DDONE visit.
  - wb_halt while adv=0: no transition until adv=1.

Decomposition:
- dp_types_pkg gains:
  - hzd_state_t enum {RUN, DWAIT, DDONE, HALT}, 2-bit.
  - A pipe_ctrl_t packed struct bundling each register's en/flush pair.
- pipeline_reg_if gains a hazard-unit modport that drives the en/flush signals.
- One sub-module: load_use_detect, the combinational lu comparator.
- The FSM and counter stay in the top.

Test Plan:
- Reset: RST=1 for 2 cycles with ihit=1 -> all outputs 0, stall_cnt=0. Release with ihit=1, dreq=0 -> all enables 1 next cycle.
- Data wait: dreq=1, dhit=0 for 3 cycles, then dhit=ihit=1 -> state DWAIT, enables 0 for 3 cycles; advance on the 4th; stall_cnt=3.
- DDONE path: dreq=1, dhit=1, ihit=0, then ihit=0, then ihit=1 -> dmem_mask=1 for exactly 2 cycles; advance on the 3rd; state returns to RUN.
- Load-use: ex_memread=1, ex_rd=8, id_rt=8, ihit=1 -> pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1; stall_cnt +1. Same with ex_rd=0 -> no bubble.
- Branch beats load-use: mem_pcsrc=1 and lu=1, ihit=1 -> if_id/id_ex/ex_mem flush=1, pc_en=1, mem_wb_flush=0.
- Halt plus mid-wait reset:
  - wb_halt=1, ihit=1 -> halt=1 next cycle; enables stay 0 for 10 cycles regardless of ihit.
  - Separately, RST=1 during DWAIT -> RUN and counter 0 the following cycle.
